// File: rtl/pointer_pkg.sv
// Shared types and constants for the board pointer controller.
package pointer_pkg;

  localparam int unsigned GRID_MAX_DEFAULT = 15;
  localparam int unsigned COORD_W          = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam int unsigned UP      = 0;
  localparam int unsigned DOWN    = 1;
  localparam int unsigned LEFT    = 2;
  localparam int unsigned RIGHT   = 3;
  localparam int unsigned NUM_DIR = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pointer_ctrl_btn_repeat.sv
// Press detector with hold-to-repeat for one direction button; step is a
// registered one-cycle pulse on the press and on every repeat.
module btn_repeat #(
  parameter int unsigned REPEAT_FIRST = 25_000_000,
  parameter int unsigned REPEAT_NEXT  = 5_000_000,
  parameter int unsigned CW           = 25
) (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  input  logic enable,
  output logic step
);

  logic          armed_q, armed_d;
  logic          prev_q, prev_d;
  logic          active_q, active_d;
  logic          first_q, first_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;

  always_comb begin
    armed_d  = 1'b1;
    prev_d   = level;
    step_d   = 1'b0;
    active_d = active_q;
    first_d  = first_q;
    cnt_d    = cnt_q;
    if (!enable || !level) begin
      active_d = 1'b0;
      first_d  = 1'b0;
      cnt_d    = '0;
    end else if (armed_q && !prev_q) begin
      // armed_q masks levels already high when reset releases
      step_d   = 1'b1;
      active_d = 1'b1;
      first_d  = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      if (first_q && cnt_q == CW'(REPEAT_FIRST - 1)) begin
        step_d  = 1'b1;
        first_d = 1'b0;
        cnt_d   = '0;
      end else if (!first_q && cnt_q == CW'(REPEAT_NEXT - 1)) begin
        step_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed_q  <= 1'b0;
      prev_q   <= 1'b0;
      active_q <= 1'b0;
      first_q  <= 1'b0;
      cnt_q    <= '0;
      step_q   <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      prev_q   <= prev_d;
      active_q <= active_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/pointer_ctrl.sv
// Cursor/placement controller: priority mux, wrapping X/Y cursor, place
// request handshake with timeout, and turn tracking.
module pointer_ctrl
  import pointer_pkg::*;
#(
  parameter int unsigned GRID_MAX     = GRID_MAX_DEFAULT,
  parameter int unsigned REPEAT_FIRST = 25_000_000,
  parameter int unsigned REPEAT_NEXT  = 5_000_000,
  parameter int unsigned ACK_TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_place,
  input  logic               home,
  input  logic               place_ack,
  input  logic               place_reject,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               place_req,
  output logic               turn,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned CW = $clog2(max3(REPEAT_FIRST, REPEAT_NEXT, ACK_TIMEOUT) + 1);
  localparam logic [COORD_W-1:0] CMAX = COORD_W'(GRID_MAX);

  function automatic logic [COORD_W-1:0] wrap_inc(input logic [COORD_W-1:0] v);
    return (v == CMAX) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [COORD_W-1:0] wrap_dec(input logic [COORD_W-1:0] v);
    return (v == '0) ? CMAX : v - 1'b1;
  endfunction

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic                 place_req_q, place_req_d, busy_q, busy_d;
  logic                 turn_q, turn_d, timeout_err_q, timeout_err_d;
  logic [CW-1:0]        tmo_q, tmo_d;
  logic                 armed_q, place_prev_q, home_prev_q;
  logic                 place_ev_q, place_ev_d, home_ev_q, home_ev_d;
  logic                 ack_q, ack_d, rej_q, rej_d;
  logic                 idle;
  logic [NUM_DIR-1:0]   level, step;

  assign idle  = (state_q == IDLE);
  assign level = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < NUM_DIR; i++) begin : g_dir
    btn_repeat #(
      .REPEAT_FIRST(REPEAT_FIRST),
      .REPEAT_NEXT (REPEAT_NEXT),
      .CW          (CW)
    ) u_rep (
      .clk   (clk),
      .resetn(resetn),
      .level (level[i]),
      .enable(idle),
      .step  (step[i])
    );
  end

  // Presses seen while in REQ are discarded here, not deferred.
  assign place_ev_d = armed_q && btn_place && !place_prev_q && idle;
  assign home_ev_d  = armed_q && home && !home_prev_q && idle;
  assign ack_d      = place_ack && place_req_q;
  assign rej_d      = place_reject && place_req_q;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    place_req_d   = place_req_q;
    busy_d        = busy_q;
    turn_d        = turn_q;
    timeout_err_d = 1'b0;
    tmo_d         = tmo_q;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (home_ev_q) begin
          x_d = '0;
          y_d = '0;
        end else if (place_ev_q) begin
          state_d     = REQ;
          place_req_d = 1'b1;
          busy_d      = 1'b1;
        end else if (step[UP])    y_d = wrap_dec(y_q);
        else if (step[DOWN])      y_d = wrap_inc(y_q);
        else if (step[LEFT])      x_d = wrap_dec(x_q);
        else if (step[RIGHT])     x_d = wrap_inc(x_q);
      end
      REQ: begin
        if (ack_q || rej_q) begin
          state_d     = IDLE;
          place_req_d = 1'b0;
          busy_d      = 1'b0;
          if (!rej_q) turn_d = ~turn_q;
        end else if (tmo_q == CW'(ACK_TIMEOUT - 1)) begin
          state_d       = IDLE;
          place_req_d   = 1'b0;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      place_req_q   <= 1'b0;
      busy_q        <= 1'b0;
      turn_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_q         <= '0;
      armed_q       <= 1'b0;
      place_prev_q  <= 1'b0;
      home_prev_q   <= 1'b0;
      place_ev_q    <= 1'b0;
      home_ev_q     <= 1'b0;
      ack_q         <= 1'b0;
      rej_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      place_req_q   <= place_req_d;
      busy_q        <= busy_d;
      turn_q        <= turn_d;
      timeout_err_q <= timeout_err_d;
      tmo_q         <= tmo_d;
      armed_q       <= 1'b1;
      place_prev_q  <= btn_place;
      home_prev_q   <= home;
      place_ev_q    <= place_ev_d;
      home_ev_q     <= home_ev_d;
      ack_q         <= ack_d;
      rej_q         <= rej_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign place_req   = place_req_q;
  assign turn        = turn_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/pointer_ctrl.md
# pointer_ctrl

Cursor and placement controller for the board pointer. Takes debounced direction and place buttons, sequences the X/Y cursor over the 16×16 grid with wrap-around and hold-to-repeat, and runs a request/acknowledge handshake with the board-state logic to place a stone. It tracks whose turn it is. It replaces the free-running per-axis coordinate counters with a single clocked controller.

## Interface
- GRID_MAX, 15: last valid coordinate on each axis (4-bit coordinates).
- REPEAT_FIRST, 25_000_000: cycles a direction must be held after its first step before auto-repeat begins.
- REPEAT_NEXT, 5_000_000: cycles between subsequent auto-repeat steps.
- ACK_TIMEOUT, 1024: cycles to wait for ack/reject before abandoning a placement.

- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced, synchronous levels.
- btn_place  in  1  debounced level; requests a placement at the cursor.
- home  in  1  synchronous; returns the cursor to (0,0).
- place_ack  in  1  board accepted the placement (cell was empty).
- place_reject  in  1  board refused the placement (cell occupied).
- x_out, y_out  out  4  cursor coordinates.
- place_req  out  1  placement request, held until a response arrives.
- turn  out  1  current player (0 = black, 1 = white).
- busy  out  1  high while in REQ.
- timeout_err  out  1  one-cycle pulse when a placement is abandoned.

## Operation
- Reset values: x_out=0, y_out=0, place_req=0, turn=0, busy=0, timeout_err=0, FSM=IDLE, repeat counters=0, edge registers=0.
- Edge detection:
  - A press is the sampled level 1 with the previous sample 0.
  - Levels that are already high when reset releases do not count as presses.
- Movement:
  - up: y−1. down: y+1. left: x−1. right: x+1.
  - Each axis wraps around: GRID_MAX+1 → 0 and 0−1 → GRID_MAX.
- Priority when several events occur in the same cycle: home > place > up > down > left > right. At most one coordinate step is applied per cycle.
- Auto-repeat:
  - Tracked per direction while that button stays high.
  - The first step occurs on the press.
  - After REPEAT_FIRST cycles a second step occurs, then one step every REPEAT_NEXT cycles.
  - Release clears that direction's counter.
  - btn_place and home never auto-repeat.
- FSM: IDLE, REQ.
  - IDLE → REQ on a place press. place_req and busy go to 1.
  - REQ → IDLE on place_ack: turn toggles.
  - REQ → IDLE on place_reject: turn is unchanged.
  - If ack and reject are both high in the same cycle, treat it as reject.
  - REQ → IDLE after ACK_TIMEOUT cycles with no response: timeout_err pulses and turn is unchanged.
- In REQ:
  - Direction presses are ignored, and repeat counters are held at 0, so the cursor is frozen and x/y stay stable for the board.
  - home is still honoured, but only after returning to IDLE; a home asserted during REQ is dropped.
- Asserting resetn low at any time (including mid-REQ) returns every output to its reset value asynchronously.

## Timing
- Press sampled at edge N → coordinate updated at edge N+1, i.e. 1-cycle latency from the sampling edge.
- Place press sampled at edge N → place_req=1 after edge N+1.
- Response sampled at edge M → place_req=0 and turn updated after edge M+1.
- Timeout: place_req drops and timeout_err pulses after the ACK_TIMEOUT-th REQ cycle without a response.
- Auto-repeat steps occur exactly REPEAT_FIRST, REPEAT_FIRST+REPEAT_NEXT, … cycles after the first step.
- Counters are wide enough for max(REPEAT_FIRST, REPEAT_NEXT, ACK_TIMEOUT); use $clog2.

## Structure
- Package pointer_pkg:
  - GRID_MAX default.
  - FSM state enum (IDLE, REQ).
  - Direction index constants (UP, DOWN, LEFT, RIGHT).
- Sub-module btn_repeat, instantiated four times, one per direction:
  - Inputs: clk, resetn, level, enable.
  - Output: step (one-cycle pulse on press and on each repeat).
- Top level: priority mux, X/Y wrap arithmetic, FSM, timeout counter, turn register.

## Test plan
- Reset, then right pressed 16 single cycles → x_out goes 1…15 then 0; y_out stays 0.
- From (0,0), a single up press → y_out=15. Then left press → x_out=15.
- REPEAT_FIRST=8, REPEAT_NEXT=4, right held 20 cycles → steps at cycles 0, 8, 12, 16; x_out=4.
- Place press, ack 3 cycles later:
  - place_req is high for the cycles in between.
  - turn goes 0→1.
  - A second place press with reject → turn stays 1 and place_req drops.
- ACK_TIMEOUT=16, place press with no response → place_req falls after 16 cycles, timeout_err pulses once, and direction presses during REQ leave x/y unchanged.
- resetn pulsed low mid-REQ with cursor at (7,9) → all outputs return to reset values immediately; btn_right held through the release does not step.
